// File: rtl/alu_issue_queue.sv
// Issue queue feeding an external ALU: buffers instructions in a FIFO, issues one at a time,
// parks the ALU between instructions, and holds each result until the consumer accepts it.
module alu_issue_queue #(
    parameter int          DEPTH   = 4,
    parameter int          ALU_LAT = 1,
    parameter logic [3:0]  PARK_OP = 4'b1001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_opcode,
    input  logic [7:0] in_A,
    input  logic [7:0] in_B,
    output logic [3:0] opcode,
    output logic [7:0] A,
    output logic [7:0] B,
    input  logic [7:0] ALU_Out,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic [3:0] res_opcode,
    output logic       illegal,
    output logic       busy
);

    // state   | meaning
    // IDLE    | ALU parked, waiting for a FIFO head
    // ISSUE   | operands on the ALU ports for ALU_LAT cycles
    // CAPTURE | ALU parked again, result sampled at the closing edge
    // HOLD    | result presented until res_ready

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [AW:0]      FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ALU_LAT - 1);
    localparam logic [3:0]       LAST_LEGAL = 4'b1010;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

    state_t state, state_nxt;

    logic [3:0] q_op [DEPTH];
    logic [7:0] q_a  [DEPTH];
    logic [7:0] q_b  [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, push, pop, head_legal, issue, drop;
    logic [CNT_W-1:0] lat_cnt;
    logic [3:0]    iss_op;

    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign in_ready   = !full;
    assign push       = in_valid && !full;
    assign head_legal = (q_op[rd_ptr] <= LAST_LEGAL);

    // FIFO storage needs no reset; validity is tracked by count
    always_ff @(posedge clk) begin
        if (push) begin
            q_op[wr_ptr] <= in_opcode;
            q_a[wr_ptr]  <= in_A;
            q_b[wr_ptr]  <= in_B;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty && head_legal) state_nxt = ISSUE;
            ISSUE:   if (lat_cnt == '0) state_nxt = CAPTURE;
            CAPTURE: state_nxt = HOLD;
            HOLD:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop       = (state == IDLE) && !empty;
        issue     = pop && head_legal;
        drop      = pop && !head_legal;
        res_valid = (state == HOLD);
        busy      = (state != IDLE) || !empty;
    end

    // Operands are parked on the same edge that leaves ISSUE so accumulating ops apply once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode     <= PARK_OP;
            A          <= '0;
            B          <= '0;
            iss_op     <= '0;
            lat_cnt    <= '0;
            res_data   <= '0;
            res_opcode <= '0;
            illegal    <= 1'b0;
        end else begin
            illegal <= drop;
            if (issue) begin
                opcode  <= q_op[rd_ptr];
                A       <= q_a[rd_ptr];
                B       <= q_b[rd_ptr];
                iss_op  <= q_op[rd_ptr];
                lat_cnt <= LAT_LOAD;
            end else if (state == ISSUE) begin
                if (lat_cnt == '0) begin
                    opcode <= PARK_OP;
                    A      <= '0;
                    B      <= '0;
                end else begin
                    lat_cnt <= lat_cnt - 1'b1;
                end
            end
            if (state == CAPTURE) begin
                res_data   <= ALU_Out;
                res_opcode <= iss_op;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: behavioural ALU with accumulator, in-order result scoreboard,
// directed scenarios and a randomized instruction stream.
module tb_alu_issue_queue;

    localparam logic [3:0] PARK_OP = 4'b1001;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_opcode;
    logic [7:0] in_A;
    logic [7:0] in_B;
    logic [3:0] opcode;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] ALU_Out;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [3:0] res_opcode;
    logic       illegal;
    logic       busy;

    logic       acc_clr;
    logic [7:0] alu_acc;

    int tests = 0;
    int fails = 0;
    int ill_seen = 0;
    int exp_ill = 0;
    int issue_cycles = 0;
    bit rand_rdy = 0;
    logic [7:0]  model_acc = 8'h00;
    logic [11:0] exp_q[$];
    logic [11:0] obs_q[$];

    alu_issue_queue #(.DEPTH(4), .ALU_LAT(1), .PARK_OP(PARK_OP)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_A(in_A), .in_B(in_B),
        .opcode(opcode), .A(A), .B(B), .ALU_Out(ALU_Out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_opcode(res_opcode), .illegal(illegal), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] acc_next(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] acc);
        case (op)
            4'd4:    acc_next = acc + a;
            4'd5:    acc_next = acc * a;
            4'd6:    acc_next = acc + a * b;
            default: acc_next = acc;
        endcase
    endfunction

    function automatic logic [7:0] alu_res(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] acc);
        case (op)
            4'd0:    alu_res = a + b;
            4'd1:    alu_res = a - b;
            4'd2:    alu_res = a * b;
            4'd3:    alu_res = (b == 8'h00) ? 8'hFF : a / b;
            4'd4, 4'd5, 4'd6: alu_res = acc_next(op, a, b, acc);
            4'd7:    alu_res = {a[6:0], a[7]};
            4'd8:    alu_res = {a[0], a[7:1]};
            4'd9:    alu_res = a & b;
            4'd10:   alu_res = a | b;
            default: alu_res = 8'h00;
        endcase
    endfunction

    // External ALU with one cycle of latency and a persistent accumulator
    always @(posedge clk) begin
        ALU_Out <= alu_res(opcode, A, B, alu_acc);
        alu_acc <= acc_clr ? 8'h00 : acc_next(opcode, A, B, alu_acc);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [11:0] e;
        @(negedge clk);
        if (!rst) begin
            if (res_valid && res_ready) begin
                obs_q.push_back({res_opcode, res_data});
                if (exp_q.size() == 0) begin
                    chk("spurious_result", 32'(res_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_opcode", 32'(res_opcode), 32'(e[11:8]));
                    chk("res_data", 32'(res_data), 32'(e[7:0]));
                end
            end
            if (illegal) ill_seen++;
        end
        @(posedge clk);
        #1;
        if (rand_rdy) res_ready = 1'($urandom_range(0, 1));
        if (opcode != PARK_OP) issue_cycles++;
    endtask

    task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        bit done = 0;
        in_valid  = 1'b1;
        in_opcode = op;
        in_A      = a;
        in_B      = b;
        for (int i = 0; i < 200 && !done; i++) begin
            if (in_ready) begin
                if (op <= 4'd10) begin
                    exp_q.push_back({op, alu_res(op, a, b, model_acc)});
                    model_acc = acc_next(op, a, b, model_acc);
                end else begin
                    exp_ill++;
                end
                done = 1;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!done) chk("push_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic drain();
        bit done = 0;
        rand_rdy  = 0;
        res_ready = 1'b1;
        for (int i = 0; i < 600 && !done; i++) begin
            if (exp_q.size() == 0 && !busy) done = 1;
            else tick();
        end
        if (!done) chk("drain_timeout", 32'(busy), 32'd0);
    endtask

    function automatic logic [3:0] rand_nonacc();
        case ($urandom_range(0, 7))
            0:       rand_nonacc = 4'd0;
            1:       rand_nonacc = 4'd1;
            2:       rand_nonacc = 4'd2;
            3:       rand_nonacc = 4'd3;
            4:       rand_nonacc = 4'd7;
            5:       rand_nonacc = 4'd8;
            6:       rand_nonacc = 4'd9;
            default: rand_nonacc = 4'd10;
        endcase
    endfunction

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_ready"},   32'(in_ready),   32'd1);
        chk({tag, "_opcode"},     32'(opcode),     32'(PARK_OP));
        chk({tag, "_A"},          32'(A),          32'd0);
        chk({tag, "_B"},          32'(B),          32'd0);
        chk({tag, "_res_valid"},  32'(res_valid),  32'd0);
        chk({tag, "_res_data"},   32'(res_data),   32'd0);
        chk({tag, "_res_opcode"}, 32'(res_opcode), 32'd0);
        chk({tag, "_illegal"},    32'(illegal),    32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd0);
    endtask

    initial begin
        logic [3:0] op;
        logic [3:0] op2;
        logic [7:0] hold_data;
        int ill0;
        bit seen;

        rst = 1'b0; in_valid = 1'b0; in_opcode = '0; in_A = '0; in_B = '0;
        res_ready = 1'b0; acc_clr = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk_reset_values("reset");
        tick(); tick();
        rst = 1'b0;
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        model_acc = 8'h00;

        // Single ADD: one issue cycle, result two cycles after operands appear
        res_ready = 1'b1;
        push(4'b0000, 8'h0A, 8'h05);
        chk("add_parked_before", 32'(opcode), 32'(PARK_OP));
        chk("add_busy", 32'(busy), 32'd1);
        tick();
        chk("add_issue_op", 32'(opcode), 32'd0);
        chk("add_issue_A", 32'(A), 32'h0A);
        chk("add_issue_B", 32'(B), 32'h05);
        chk("add_no_early_valid", 32'(res_valid), 32'd0);
        tick();
        chk("add_capture_parked", 32'(opcode), 32'(PARK_OP));
        chk("add_capture_A0", 32'(A), 32'd0);
        chk("add_capture_valid", 32'(res_valid), 32'd0);
        tick();
        chk("add_hold_valid", 32'(res_valid), 32'd1);
        chk("add_hold_data", 32'(res_data), 32'h0F);
        chk("add_hold_op", 32'(res_opcode), 32'd0);
        tick();
        chk("add_after_valid", 32'(res_valid), 32'd0);
        chk("add_after_busy", 32'(busy), 32'd0);

        // Three MACs from a cleared accumulator
        acc_clr = 1'b1; tick(); acc_clr = 1'b0; model_acc = 8'h00;
        obs_q.delete();
        push(4'd6, 8'd8, 8'd1);
        push(4'd6, 8'd52, 8'd2);
        push(4'd6, 8'd4, 8'd10);
        drain();
        chk("mac_count", 32'(obs_q.size()), 32'd3);
        if (obs_q.size() == 3) begin
            chk("mac_res0", 32'(obs_q[0][7:0]), 32'd8);
            chk("mac_res1", 32'(obs_q[1][7:0]), 32'd112);
            chk("mac_res2", 32'(obs_q[2][7:0]), 32'd152);
        end

        // Illegal opcode dropped, following SUB still executes
        obs_q.delete();
        ill0 = ill_seen;
        push(4'b1111, 8'h33, 8'h44);
        push(4'b0001, 8'h00, 8'h01);
        drain();
        chk("illegal_pulses", 32'(ill_seen - ill0), 32'd1);
        chk("illegal_result_count", 32'(obs_q.size()), 32'd1);
        if (obs_q.size() == 1) begin
            chk("sub_res", 32'(obs_q[0][7:0]), 32'hFF);
            chk("sub_op", 32'(obs_q[0][11:8]), 32'd1);
        end

        // ROL then ROR; only one issue cycle per instruction
        obs_q.delete();
        issue_cycles = 0;
        push(4'd7, 8'h80, 8'h00);
        push(4'd8, 8'h01, 8'h00);
        drain();
        chk("rot_issue_cycles", 32'(issue_cycles), 32'd2);
        chk("rot_parked_end", 32'(opcode), 32'(PARK_OP));
        if (obs_q.size() == 2) begin
            chk("rol_res", 32'(obs_q[0][7:0]), 32'h01);
            chk("ror_res", 32'(obs_q[1][7:0]), 32'h80);
        end else begin
            chk("rot_count", 32'(obs_q.size()), 32'd2);
        end

        // Backpressure: one in HOLD, four queued, sixth refused until the consumer drains
        obs_q.delete();
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(rand_nonacc(), 8'($urandom), 8'($urandom));
        chk("bp_full_in_ready", 32'(in_ready), 32'd0);
        chk("bp_hold_valid", 32'(res_valid), 32'd1);
        hold_data = exp_q[0][7:0];
        in_valid = 1'b1; in_opcode = 4'd0; in_A = 8'h21; in_B = 8'h12;
        tick();
        chk("bp_sixth_refused", 32'(in_ready), 32'd0);
        chk("bp_hold_stable", 32'(res_data), 32'(hold_data));
        res_ready = 1'b1;
        push(4'd0, 8'h21, 8'h12);
        drain();
        chk("bp_drain_count", 32'(obs_q.size()), 32'd6);

        // Randomized stream with random consumer stalls
        rand_rdy = 1;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 7) == 0) op = 4'($urandom_range(11, 15));
            else                            op = 4'($urandom_range(0, 10));
            push(op, 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 3) == 0) tick();
        end
        drain();
        chk("rand_illegal_count", 32'(ill_seen), 32'(exp_ill));
        chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset while ISSUE with three entries queued
        res_ready = 1'b0;
        op2 = rand_nonacc();
        push(rand_nonacc(), 8'($urandom), 8'($urandom));
        push(op2, 8'($urandom), 8'($urandom));
        for (int i = 0; i < 3; i++) push(rand_nonacc(), 8'($urandom), 8'($urandom));
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (res_valid) seen = 1;
            else tick();
        end
        chk("rst_reach_hold", 32'(res_valid), 32'd1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tick();
        chk("rst_in_issue_op", 32'(opcode), 32'(op2));
        #2 rst = 1'b1;
        #1;
        chk_reset_values("midrst");
        exp_q.delete();
        obs_q.delete();
        tick(); tick();
        rst = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("midrst_no_result", 32'(obs_q.size()), 32'd0);
        chk("midrst_idle_busy", 32'(busy), 32'd0);
        chk("midrst_parked", 32'(opcode), 32'(PARK_OP));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 SHALL have parameters: DEPTH, 4, instruction FIFO entries (power of 2).
REQ-002 SHALL have parameters: ALU_LAT, 1, clock cycles from operands presented to ALU_Out valid.
REQ-003 SHALL have parameters: PARK_OP, 4'b1001, opcode driven to the ALU when idle (AND, non-accumulating).
REQ-004 SHALL have ports:
  clk  input  1  single clock; all state updates on rising edge.
  rst  input  1  asynchronous, active-high reset.
  in_valid  input  1  host instruction valid.
  in_ready  output  1  FIFO can accept an instruction.
  in_opcode  input  4  instruction opcode.
  in_A  input  8  operand A.
  in_B  input  8  operand B.
  opcode  output  4  opcode to the ALU.
  A  output  8  operand A to the ALU.
  B  output  8  operand B to the ALU.
  ALU_Out  input  8  ALU result.
  res_valid  output  1  result available.
  res_ready  input  1  consumer accepts result.
  res_data  output  8  captured ALU result.
  res_opcode  output  4  opcode that produced res_data.
  illegal  output  1  one-cycle pulse when an illegal opcode is dropped.
  busy  output  1  high when FSM is not IDLE or FIFO is not empty.

Function
REQ-005 Legal opcodes SHALL be 4'b0000-4'b1010 (ADD, SUB, MUL, DIV, ADDA, MULA, MAC, ROL, ROR, AND, OR); 4'b1011-4'b1111 SHALL be illegal.
REQ-006 FIFO push SHALL occur on in_valid && in_ready; in_ready = !full; no bypass: a full FIFO SHALL refuse a push even in a cycle where it also pops.
REQ-007 An entry pushed in cycle t SHALL be poppable no earlier than cycle t+1.
REQ-008 FSM states SHALL be IDLE, ISSUE, CAPTURE, HOLD.
REQ-009 IDLE with FIFO non-empty and a legal head SHALL pop the head, register opcode/A/B, and go to ISSUE.
REQ-010 IDLE with an illegal head SHALL pop it, pulse illegal for one cycle, leave opcode/A/B parked, and remain in IDLE.
REQ-011 ISSUE SHALL hold opcode/A/B stable for exactly ALU_LAT cycles, then go to CAPTURE and drive opcode=PARK_OP, A=0, B=0, so accumulating ops (ADDA, MULA, MAC) update the ALU accumulator exactly once per instruction.
REQ-012 CAPTURE (one cycle) SHALL sample ALU_Out into res_data and the issued opcode into res_opcode at its closing edge, then go to HOLD.
REQ-013 HOLD SHALL assert res_valid, keeping res_data and res_opcode stable, until res_valid && res_ready; IDLE is entered on that edge.
REQ-014 Results SHALL emerge in push order; one instruction in flight at a time.
REQ-015 With operands first on the ALU ports in cycle k, res_valid SHALL rise in cycle k+ALU_LAT+1.
REQ-016 The FIFO SHALL keep accepting pushes while the FSM is in ISSUE, CAPTURE or HOLD.

Reset
REQ-017 rst SHALL asynchronously force: FIFO empty, FSM IDLE, in_ready=1, opcode=PARK_OP, A=0, B=0, res_valid=0, res_data=0, res_opcode=0, illegal=0, busy=0.
REQ-018 Reset mid-operation SHALL discard the in-flight instruction and all queued entries; the ALU accumulator is not reset by this block.

Verification
REQ-019 Push ADD A=8'h0A B=8'h05, res_ready=1 -> operands on ALU ports for 1 cycle, res_valid pulses with res_data=8'h0F, res_opcode=4'b0000.
REQ-020 ALU acc=0; push MAC (8,1), (52,2), (4,10) -> res_data 8, 112, 152 in order; each MAC is applied once.
REQ-021 Push opcode 4'b1111, then SUB A=0 B=1 -> one illegal pulse, no result for 4'b1111, then res_data=8'hFF.
REQ-022 res_ready=0, push 6 instructions back-to-back -> 1 in HOLD, 4 queued, in_ready low on the 6th; releasing res_ready drains all 5 in order.
REQ-023 Assert rst during ISSUE with 3 entries queued -> all outputs take their reset values immediately; busy=0; no result is ever produced.
REQ-024 ROL A=8'h80 then ROR A=8'h01 -> res_data 8'h01 then 8'h80; opcode returns to PARK_OP between instructions.
